// File: rtl/pc_flow_if.sv
// rtl/pc_flow_if.sv - decoder, program counter and stack memory signals of the flow controller
interface pc_flow_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) ();
    // decoder request
    logic                  start;
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] target_addr;
    logic [ADDR_WIDTH-1:0] pc_value;
    // program counter byte loads
    logic                  pc_load_high;
    logic                  pc_load_low;
    logic [DATA_WIDTH-1:0] pc_data;
    // stack memory handshake
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_we;
    logic                  mem_re;
    logic                  mem_ready;
    // status
    logic                  busy;
    logic                  done;
    logic                  stack_fault;
    logic [DATA_WIDTH-1:0] sp_out;

    modport master (
        input  start, op, target_addr, pc_value, mem_rdata, mem_ready,
        output pc_load_high, pc_load_low, pc_data, mem_addr, mem_wdata,
               mem_we, mem_re, busy, done, stack_fault, sp_out
    );

    modport slave (
        output start, op, target_addr, pc_value, mem_rdata, mem_ready,
        input  pc_load_high, pc_load_low, pc_data, mem_addr, mem_wdata,
               mem_we, mem_re, busy, done, stack_fault, sp_out
    );
endinterface

// File: rtl/pc_flow_controller.sv
// rtl/pc_flow_controller.sv - JMP/CALL/RET sequencer driving PC byte loads and the hardware stack
module pc_flow_controller #(
    parameter int                        DATA_WIDTH = 8,
    parameter int                        ADDR_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0]     STACK_PAGE = 8'h01,
    parameter logic [DATA_WIDTH-1:0]     SP_RESET   = 8'hFF
) (
    input  logic    clk,
    input  logic    reset,
    pc_flow_if.master bus
);
    localparam logic [1:0] OP_JMP  = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_RET  = 2'b10;

    // A CALL needs two free slots, a RET needs two stacked bytes.
    localparam logic [DATA_WIDTH-1:0] CALL_MIN_SP = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] RET_MAX_SP  = SP_RESET - DATA_WIDTH'(2);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        POP_LO,
        POP_HI,
        LOAD_HI,
        LOAD_LO,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sp_q, sp_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic [ADDR_WIDTH-1:0] ret_q, ret_d;
    logic                  fault_q, fault_d;

    logic [DATA_WIDTH-1:0] sp_inc;
    logic [DATA_WIDTH-1:0] sp_dec;

    assign sp_inc = sp_q + DATA_WIDTH'(1);
    assign sp_dec = sp_q - DATA_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sp_q    <= SP_RESET;
            dest_q  <= '0;
            ret_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            dest_q  <= dest_d;
            ret_q   <= ret_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        dest_d  = dest_q;
        ret_d   = ret_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dest_d  = bus.target_addr;
                    ret_d   = bus.pc_value;
                    fault_d = 1'b0;
                    case (bus.op)
                        OP_JMP:  state_d = LOAD_HI;
                        OP_CALL: begin
                            if (sp_q < CALL_MIN_SP) begin
                                fault_d = 1'b1;
                                state_d = DONE;
                            end else begin
                                state_d = PUSH_HI;
                            end
                        end
                        OP_RET: begin
                            if (sp_q > RET_MAX_SP) begin
                                fault_d = 1'b1;
                                state_d = DONE;
                            end else begin
                                state_d = POP_LO;
                            end
                        end
                        default: state_d = DONE;
                    endcase
                end
            end
            PUSH_HI: begin
                if (bus.mem_ready) begin
                    sp_d    = sp_dec;
                    state_d = PUSH_LO;
                end
            end
            PUSH_LO: begin
                if (bus.mem_ready) begin
                    sp_d    = sp_dec;
                    state_d = LOAD_HI;
                end
            end
            POP_LO: begin
                if (bus.mem_ready) begin
                    dest_d[DATA_WIDTH-1:0] = bus.mem_rdata;
                    sp_d    = sp_inc;
                    state_d = POP_HI;
                end
            end
            POP_HI: begin
                if (bus.mem_ready) begin
                    dest_d[ADDR_WIDTH-1:DATA_WIDTH] = bus.mem_rdata;
                    sp_d    = sp_inc;
                    state_d = LOAD_HI;
                end
            end
            LOAD_HI: state_d = LOAD_LO;
            LOAD_LO: state_d = DONE;
            DONE: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on state only, so they stay stable while memory waits.
    always_comb begin
        bus.pc_load_high = 1'b0;
        bus.pc_load_low  = 1'b0;
        bus.pc_data      = '0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.mem_we       = 1'b0;
        bus.mem_re       = 1'b0;
        bus.done         = 1'b0;
        bus.stack_fault  = 1'b0;
        case (state_q)
            PUSH_HI: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {STACK_PAGE, sp_q};
                bus.mem_wdata = ret_q[ADDR_WIDTH-1:DATA_WIDTH];
            end
            PUSH_LO: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {STACK_PAGE, sp_q};
                bus.mem_wdata = ret_q[DATA_WIDTH-1:0];
            end
            POP_LO, POP_HI: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = {STACK_PAGE, sp_inc};
            end
            LOAD_HI: begin
                bus.pc_load_high = 1'b1;
                bus.pc_data      = dest_q[ADDR_WIDTH-1:DATA_WIDTH];
            end
            LOAD_LO: begin
                bus.pc_load_low = 1'b1;
                bus.pc_data     = dest_q[DATA_WIDTH-1:0];
            end
            DONE: begin
                bus.done        = 1'b1;
                bus.stack_fault = fault_q;
            end
            default: ;
        endcase
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.sp_out = sp_q;

endmodule
